// File: rtl/accum_stage.sv
// Sums groups of accum_size signed partials; each sum is visible the cycle after its last input.
// Input side has no backpressure; a sum that finds the 2-entry output queue full is dropped and sets sticky overflow.
module accum_stage #(
  parameter int DATAW  = 32,
  parameter int ACCUMW = 32,
  parameter int CNTW   = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [DATAW-1:0]  data,
  input  logic                     ivalid,
  input  logic        [CNTW-1:0]   accum_size,
  output logic signed [ACCUMW-1:0] result,
  output logic                     ovalid,
  input  logic                     oready,
  output logic                     busy,
  output logic                     overflow
);

  logic        [CNTW-1:0]   cnt;
  logic        [CNTW-1:0]   size_q;
  logic        [CNTW-1:0]   size_sel;
  logic        [CNTW-1:0]   size_eff;
  logic signed [ACCUMW-1:0] acc;
  logic signed [ACCUMW-1:0] data_ext;
  logic signed [ACCUMW-1:0] sum_dat;
  logic                     sum_vld;
  logic                     last;

  logic signed [ACCUMW-1:0] q_mem [2];
  logic                     q_rd;
  logic                     q_wr;
  logic        [1:0]        q_cnt;
  logic                     q_empty;
  logic                     q_full;
  logic                     pop;
  logic                     push_ok;

  always_comb begin
    // The group size is taken live on the first partial, latched thereafter.
    size_sel = (cnt == '0) ? accum_size : size_q;
    size_eff = (size_sel == '0) ? CNTW'(1) : size_sel;
    last     = (cnt == size_eff - CNTW'(1));
    data_ext = ACCUMW'(data);
    sum_dat  = ((cnt == '0) ? '0 : acc) + data_ext;
    sum_vld  = ivalid && last;
    q_empty  = (q_cnt == 2'd0);
    q_full   = (q_cnt == 2'd2);
    pop      = oready && !q_empty;
    push_ok  = sum_vld && (!q_full || pop);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt    <= '0;
      acc    <= '0;
      size_q <= '0;
    end else if (ivalid) begin
      if (cnt == '0) size_q <= accum_size;
      if (last) begin
        cnt <= '0;
        acc <= '0;
      end else begin
        cnt <= cnt + CNTW'(1);
        acc <= sum_dat;
      end
    end
  end

  // Output queue: a pop in the same cycle frees a slot for a push into a full queue.
  always_ff @(posedge clk) begin
    if (!rst) begin
      q_mem[0] <= '0;
      q_mem[1] <= '0;
      q_rd     <= 1'b0;
      q_wr     <= 1'b0;
      q_cnt    <= 2'd0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) begin
        q_mem[q_wr] <= sum_dat;
        q_wr        <= ~q_wr;
      end
      if (pop) q_rd <= ~q_rd;
      q_cnt <= q_cnt + 2'(push_ok) - 2'(pop);
      if (sum_vld && !push_ok) overflow <= 1'b1;
    end
  end

  assign result = q_mem[q_rd];
  assign ovalid = !q_empty;
  assign busy   = (cnt != '0);

endmodule

// File: tb/tb_accum_stage.sv
// Randomized scoreboard bench for accum_stage: a group-level reference model predicts sums and drops.
module tb_accum_stage;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic signed [31:0] data = '0;
  logic               ivalid = 1'b0;
  logic        [7:0]  accum_size = '0;
  logic signed [31:0] result;
  logic               ovalid;
  logic               oready = 1'b0;
  logic               busy;
  logic               overflow;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q [$];
  logic [31:0] partials [$];
  int          target = 1;
  bit          exp_ovf = 1'b0;

  accum_stage #(.DATAW(32), .ACCUMW(32), .CNTW(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .data       (data),
    .ivalid     (ivalid),
    .accum_size (accum_size),
    .result     (result),
    .ovalid     (ovalid),
    .oready     (oready),
    .busy       (busy),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model for the upcoming clock edge: partials are collected and summed when the group fills.
  task automatic step(bit r, bit iv, logic [31:0] d, logic [7:0] sz, bit ordy);
    bit          pop;
    logic [31:0] sum;
    if (!r) begin
      partials.delete();
      exp_q.delete();
      exp_ovf = 1'b0;
      return;
    end
    pop = ordy && (exp_q.size() > 0);
    if (iv) begin
      if (partials.size() == 0) target = (sz == 0) ? 1 : int'(sz);
      partials.push_back(d);
      if (partials.size() == target) begin
        sum = '0;
        foreach (partials[i]) sum = sum + partials[i];
        partials.delete();
        if (exp_q.size() < 2 || pop) exp_q.push_back(sum);
        else exp_ovf = 1'b1;
      end
    end
  endtask

  task automatic cycle(bit r, bit iv, logic [31:0] d, logic [7:0] sz, bit ordy);
    rst = r; ivalid = iv; data = d; accum_size = sz; oready = ordy;
    step(r, iv, d, sz, ordy);
    @(posedge clk); #1;
    chk("busy", 32'(busy), 32'(partials.size() != 0));
    chk("ovalid", 32'(ovalid), 32'(exp_q.size() != 0));
    chk("overflow", 32'(overflow), 32'(exp_ovf));
  endtask

  // Monitor: every accepted output is compared against the scoreboard head.
  initial begin
    forever begin
      @(negedge clk);
      if (rst && ovalid && oready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output actual=%0h expected=none at %0t", result, $time);
        end else begin
          chk("result", result, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    logic [31:0] d;
    repeat (2) cycle(0, 0, 0, 0, 0);
    chk("reset_result", result, 32'd0);

    // Group of 4 with a known sum.
    cycle(1, 1, 32'd10, 8'd4, 1);
    chk("busy_c2", 32'(busy), 32'd1);
    cycle(1, 1, -32'sd3, 8'd4, 1);
    cycle(1, 1, 32'd7, 8'd9, 1);
    cycle(1, 1, 32'd100, 8'd9, 1);
    chk("sum4", result, 32'd114);
    chk("busy_done", 32'(busy), 32'd0);
    cycle(1, 0, 0, 0, 1);

    // Size 0 acts as 1.
    cycle(1, 1, 32'd5, 8'd0, 1);
    chk("size0_a", result, 32'd5);
    cycle(1, 1, -32'sd5, 8'd0, 1);
    chk("size0_b", result, 32'hFFFF_FFFB);
    cycle(1, 0, 0, 0, 1);

    // Wraparound.
    cycle(1, 1, 32'h7FFF_FFFF, 8'd2, 1);
    cycle(1, 1, 32'd1, 8'd2, 1);
    chk("wrap", result, 32'h8000_0000);
    cycle(1, 0, 0, 0, 1);

    // Full queue drops the third sum.
    cycle(1, 1, 32'd1, 8'd1, 0);
    cycle(1, 1, 32'd2, 8'd1, 0);
    cycle(1, 1, 32'd3, 8'd1, 0);
    chk("ovf_set", 32'(overflow), 32'd1);
    chk("head_held", result, 32'd1);
    cycle(1, 0, 0, 0, 1);
    chk("drain2", result, 32'd2);
    cycle(1, 0, 0, 0, 1);
    chk("drained", 32'(ovalid), 32'd0);
    chk("ovf_sticky", 32'(overflow), 32'd1);
    cycle(0, 0, 0, 0, 0);

    // Full queue with a simultaneous pop accepts the push.
    cycle(1, 1, 32'd1, 8'd1, 0);
    cycle(1, 1, 32'd2, 8'd1, 0);
    cycle(1, 1, 32'd3, 8'd1, 1);
    chk("pop_push_ovf", 32'(overflow), 32'd0);
    chk("pop_push_head", result, 32'd2);
    cycle(1, 0, 0, 0, 1);
    chk("pop_push_tail", result, 32'd3);
    cycle(1, 0, 0, 0, 1);

    // Reset mid-group discards the partial sum.
    cycle(1, 1, 32'd50, 8'd4, 1);
    cycle(1, 1, 32'd60, 8'd4, 1);
    cycle(0, 1, 32'd70, 8'd4, 1);
    chk("rst_busy", 32'(busy), 32'd0);
    cycle(1, 1, 32'd6, 8'd2, 1);
    cycle(1, 1, 32'd7, 8'd9, 1);
    chk("after_rst", result, 32'd13);
    cycle(1, 0, 0, 0, 1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 9))
        0:       d = 32'h7FFF_FFFF;
        1:       d = 32'h8000_0000;
        default: d = $urandom;
      endcase
      cycle(($urandom_range(0, 199) != 0), ($urandom_range(0, 3) != 0), d,
            8'($urandom_range(0, 5)), ($urandom_range(0, 2) != 0));
    end

    repeat (4) cycle(1, 0, 0, 0, 1);
    chk("final_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/accum_stage.md
ACCUM_STAGE -- requirements
Module: accum_stage

Interface
REQ-001 Parameter DATAW, 32, width of signed partial dot products consumed from the 8-lane dot-product stage.
REQ-002 Parameter ACCUMW, 32, width of the signed accumulated output (ACCUMW >= DATAW).
REQ-003 Parameter CNTW, 8, width of the group-size input and internal chunk counter.
REQ-004 clk  input  1  single clock; all state updates on rising edge only.
REQ-005 rst  input  1  synchronous, active-low reset; sampled on the clk rising edge.
REQ-006 data  input  DATAW  signed partial dot product.
REQ-007 ivalid  input  1  data valid; no backpressure toward the source, every ivalid cycle is consumed.
REQ-008 accum_size  input  CNTW  number of partials per output sum; value 0 is treated as 1.
REQ-009 result  output  ACCUMW  signed sum at output-queue head.
REQ-010 ovalid  output  1  result holds a valid sum.
REQ-011 oready  input  1  consumer accepts result this cycle.
REQ-012 busy  output  1  a group is partially accumulated (chunk counter nonzero).
REQ-013 overflow  output  1  sticky; a completed sum was dropped because the output queue was full.

Function
REQ-014 Chunk counter cnt (CNTW bits) and running sum acc (ACCUMW bits) are the group state; the group is in progress iff cnt != 0.
REQ-015 accum_size is latched into size_q on any ivalid cycle with cnt == 0; accum_size changes mid-group are ignored.
REQ-016 Each ivalid cycle adds sign-extended data to acc (cnt == 0: acc loads data, no stale contribution); addition wraps modulo 2^ACCUMW, no saturation.
REQ-017 Group completes on the ivalid cycle where cnt == effective size - 1 (effective size = latched value, 0 mapped to 1); on that edge cnt and acc clear to 0 and the final sum is pushed.
REQ-018 Latency: a completed sum is visible on result/ovalid the cycle after the last ivalid of its group when the queue was empty.
REQ-019 Back-to-back groups with no idle cycle are supported; an ivalid in the cycle after completion starts a new group at full rate.
REQ-020 Output queue: 2-entry FIFO; ovalid = not empty; result = head entry; pop on ovalid && oready.
REQ-021 result is held stable while ovalid && !oready.
REQ-022 Push and pop in the same cycle are both performed; with the queue full, a simultaneous pop makes room and the push is accepted.
REQ-023 Push into a full queue without a pop: new sum dropped, queue contents unchanged, overflow set to 1 on the next edge and held until reset.
REQ-024 oready with ovalid == 0 has no effect.
REQ-025 busy = (cnt != 0), registered state only.

Reset
REQ-026 On rst == 0 at a clk edge: cnt = 0, acc = 0, size_q = 0, queue emptied, ovalid = 0, result = 0, busy = 0, overflow = 0.
REQ-027 Reset mid-group discards the partial sum; the first ivalid after rst returns to 1 starts a new group with freshly latched accum_size.
REQ-028 ivalid and oready asserted while rst == 0 are ignored.

Verification
REQ-029 accum_size=4, data 10,-3,7,100 on 4 consecutive cycles, oready=1 -> ovalid one cycle after 4th input, result=114, busy 1 during cycles 2-4, then 0.
REQ-030 accum_size=0, data 5 then -5 on consecutive cycles -> two sums 5 and -5 on consecutive cycles, each 1 cycle after its input.
REQ-031 ACCUMW=32, accum_size=2, data 0x7FFFFFFF then 1 -> result 0x80000000 (wrap), overflow stays 0.
REQ-032 accum_size=1, oready=0, data 1,2,3 -> queue holds 1,2; 3 dropped, overflow=1 sticky; then oready=1 -> results 1 then 2, ovalid low afterward.
REQ-033 Queue full (1,2), oready=1 in same cycle as completion of sum 3 -> 1 popped, 3 accepted, overflow=0; subsequent results 2 then 3.
REQ-034 accum_size=4, 2 inputs, rst=0 one cycle, then accum_size=2 with data 6,7 -> single result 13, no output from aborted group, busy/overflow 0 after reset.
